vcu_insn_dispatcher: RTL and testbench

Hardware instruction sequencer that feeds the VCU from an on-chip instruction RAM. On a start pulse it fetches `insn_count` consecutive 128-bit instructions beginning at `insn_base`. Each instruction is presented to the VCU with a one-cycle `work_en` pulse, and the next instruction is not fetched until the VCU returns `vcu_done`. It sits between the control/host interface and the `vcu` instruction port, replacing bench-driven instruction issue in the integrated NPU.

---
 rtl/vcu_insn_dispatcher.sv | 132 +++++++++++++
 tb/tb_vcu_insn_dispatcher.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vcu_insn_dispatcher.sv
// vcu_insn_dispatcher
//
// Fetches a run of consecutive instructions from the on-chip instruction RAM
// and hands them to the VCU one at a time. The VCU gets one instruction at a
// time. The next instruction is fetched only after the VCU reports completion.
// An optional per-instruction watchdog abandons the sequence if the VCU
// never answers.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   start           one-cycle sequence request (IDLE only)
//   insn_base       first instruction address, captured with start
//   insn_count      number of instructions (0..2^AW), captured with start
//   r_addr_insn     instruction RAM read address
//   r_en_insn       instruction RAM read enable
//   r_data_insn     instruction RAM read data (one-cycle latency)
//   insn            instruction presented to the VCU
//   work_en         one-cycle execute strobe to the VCU
//   vcu_done        VCU completion (level or pulse)
//   busy            high whenever not IDLE
//   all_done        one-cycle end-of-sequence pulse
//   timeout         sticky watchdog flag
//   issued_cnt      instructions issued in the current/last sequence
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_FETCH | RAM read of base + issued_cnt
// ST_WAIT  | RAM data returns, captured into insn
// ST_ISSUE | work_en pulse, issued_cnt increments, watchdog reloads
// ST_RUN   | waiting for vcu_done, watchdog counting down
// ST_DONE  | all_done pulse
module vcu_insn_dispatcher #(
   parameter int INSN_WIDTH         = 128,
   parameter int INSN_ADDRESS_WIDTH = 10,
   parameter int TIMEOUT_CYCLES     = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [INSN_ADDRESS_WIDTH-1:0] insn_base,
   input  logic [INSN_ADDRESS_WIDTH:0]   insn_count,
   output logic [INSN_ADDRESS_WIDTH-1:0] r_addr_insn,
   output logic                          r_en_insn,
   input  logic [INSN_WIDTH-1:0]         r_data_insn,
   output logic [INSN_WIDTH-1:0]         insn,
   output logic                          work_en,
   input  logic                          vcu_done,
   output logic                          busy,
   output logic                          all_done,
   output logic                          timeout,
   output logic [INSN_ADDRESS_WIDTH:0]   issued_cnt
);

   localparam int AW    = INSN_ADDRESS_WIDTH;
   localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
   localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Down-counter starts at TIMEOUT_CYCLES-1 so that it reaches zero in the
   // last permitted RUN cycle.
   localparam logic [WD_W-1:0] WD_LOAD =
      WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT,
      ST_ISSUE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t          state;
   logic [AW-1:0]   base_q;
   logic [AW:0]     count_q;
   logic [WD_W-1:0] wd_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         base_q     <= '0;
         count_q    <= '0;
         issued_cnt <= '0;
         insn       <= '0;
         timeout    <= 1'b0;
         wd_cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q     <= insn_base;
                  count_q    <= insn_count;
                  issued_cnt <= '0;
                  timeout    <= 1'b0;
                  state      <= (insn_count == '0) ? ST_DONE : ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_WAIT;
            ST_WAIT: begin
               insn  <= r_data_insn;
               state <= ST_ISSUE;
            end
            ST_ISSUE: begin
               issued_cnt <= issued_cnt + 1'b1;
               wd_cnt     <= WD_LOAD;
               state      <= ST_RUN;
            end
            ST_RUN: begin
               // Completion wins over the watchdog in the terminal cycle.
               if (vcu_done) begin
                  state <= (issued_cnt == count_q) ? ST_DONE : ST_FETCH;
               end else if (WD_EN && (wd_cnt == '0)) begin
                  timeout <= 1'b1;
                  state   <= ST_IDLE;
               end else if (wd_cnt != '0) begin
                  wd_cnt <= wd_cnt - 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Everything below decodes registered state only; no input-to-output paths.
   assign r_en_insn   = (state == ST_FETCH);
   // Truncating to AW bits makes the address wrap past the top of the RAM.
   assign r_addr_insn = r_en_insn ? (base_q + issued_cnt[AW-1:0]) : '0;
   assign work_en     = (state == ST_ISSUE);
   assign busy        = (state != ST_IDLE);
   assign all_done    = (state == ST_DONE);

endmodule

// File: tb/tb_vcu_insn_dispatcher.sv
// tb_vcu_insn_dispatcher
//
// Bench for vcu_insn_dispatcher with a 20-cycle watchdog. Provides an
// instruction RAM with one-cycle read latency and a VCU that answers a
// programmable number of cycles after each work_en (0 = never answers).
module tb_vcu_insn_dispatcher;

   localparam int IW = 128;
   localparam int AW = 10;
   localparam int TO = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] insn_base = '0;
   logic [AW:0]   insn_count = '0;
   logic [AW-1:0] r_addr_insn;
   logic          r_en_insn;
   logic [IW-1:0] r_data_insn = '0;
   logic [IW-1:0] insn;
   logic          work_en;
   logic          vcu_done;
   logic          busy;
   logic          all_done;
   logic          timeout;
   logic [AW:0]   issued_cnt;

   int total = 0;
   int bad   = 0;

   logic [IW-1:0] mem [1024];
   int vcu_delay = 0;
   int vcnt = 0;

   vcu_insn_dispatcher #(
      .INSN_WIDTH(IW),
      .INSN_ADDRESS_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .insn_base(insn_base),
      .insn_count(insn_count),
      .r_addr_insn(r_addr_insn),
      .r_en_insn(r_en_insn),
      .r_data_insn(r_data_insn),
      .insn(insn),
      .work_en(work_en),
      .vcu_done(vcu_done),
      .busy(busy),
      .all_done(all_done),
      .timeout(timeout),
      .issued_cnt(issued_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (r_en_insn) r_data_insn <= mem[r_addr_insn];
   end

   always @(posedge clk) begin
      if (work_en) vcnt <= vcu_delay;
      else if (vcnt > 0) vcnt <= vcnt - 1;
   end
   assign vcu_done = (vcnt == 1);

   task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Starts a sequence and watches it until busy drops. idx counts cycles
   // after the start cycle, so idx 1 is the first cycle after start.
   task automatic run_seq(input int base, input int count, input int delay, input int bs_idx,
                          output int n_work, output int n_ren, output int n_adone,
                          output int adone_idx, output int first_work);
      int idx;
      bit finished;
      n_work = 0; n_ren = 0; n_adone = 0; adone_idx = -1; first_work = -1;
      vcu_delay = delay;
      @(negedge clk);
      start = 1'b1;
      insn_base = AW'(base);
      insn_count = (AW+1)'(count);
      @(posedge clk);
      idx = 0;
      finished = 1'b0;
      while (!finished && idx < 2000) begin
         @(negedge clk);
         idx++;
         start = 1'b0;
         if (idx == bs_idx) begin
            start = 1'b1;
            insn_base = 10'd500;
            insn_count = 11'd7;
         end
         if (idx == 1) chk("timeout_clear_on_start", IW'(timeout), '0);
         if (r_en_insn) begin
            chk("r_addr", IW'(r_addr_insn), IW'((base + n_ren) % 1024));
            n_ren++;
         end
         if (work_en) begin
            chk("insn_at_work_en", insn, mem[(base + n_work) % 1024]);
            if (first_work < 0) first_work = idx;
            n_work++;
         end
         if (all_done) begin
            n_adone++;
            adone_idx = idx;
         end
         if (!busy) finished = 1'b1;
      end
      if (!finished) chk("seq_cycle_bound", '0, IW'(1));
   endtask

   typedef struct {
      int base;
      int count;
      int delay;
      int bs_idx;
      int exp_issued;
      int exp_adone_idx;
      bit exp_to;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int n_work, n_ren, n_adone, adone_idx, first_work;

      for (int i = 0; i < 1024; i++)
         mem[i] = {32'(i), ~32'(i), 32'(i * 3 + 7), 32'hC0DE_0000 ^ 32'(i)};

      //          base  cnt delay bs  iss adone to
      vecs[0] = '{0,    3,  5,    6,  3,  25,   1'b0};  // normal run, busy start ignored
      vecs[1] = '{100,  0,  5,   -1,  0,  1,    1'b0};  // zero count
      vecs[2] = '{1022, 4,  2,   -1,  4,  21,   1'b0};  // address wrap
      vecs[3] = '{5,    1,  0,   -1,  1,  -1,   1'b1};  // VCU never answers
      vecs[4] = '{7,    2,  1,   -1,  2,  9,    1'b0};  // done in first RUN cycle
      vecs[5] = '{9,    1,  20,  -1,  1,  24,   1'b0};  // done in RUN cycle 19
      vecs[6] = '{9,    1,  21,  -1,  1,  -1,   1'b1};  // done one cycle too late
      vecs[7] = '{1023, 2,  3,   -1,  2,  13,   1'b0};  // wrap from last entry

      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_insn", insn, '0);
      chk("rst_work_en", IW'(work_en), '0);
      chk("rst_r_en", IW'(r_en_insn), '0);
      chk("rst_r_addr", IW'(r_addr_insn), '0);
      chk("rst_busy", IW'(busy), '0);
      chk("rst_all_done", IW'(all_done), '0);
      chk("rst_timeout", IW'(timeout), '0);
      chk("rst_issued_cnt", IW'(issued_cnt), '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         run_seq(vecs[v].base, vecs[v].count, vecs[v].delay, vecs[v].bs_idx,
                 n_work, n_ren, n_adone, adone_idx, first_work);
         chk($sformatf("v%0d_work_pulses", v), IW'(n_work), IW'(vecs[v].exp_issued));
         chk($sformatf("v%0d_fetches", v), IW'(n_ren), IW'(vecs[v].exp_issued));
         chk($sformatf("v%0d_issued_cnt", v), IW'(issued_cnt), IW'(vecs[v].exp_issued));
         chk($sformatf("v%0d_all_done_pulses", v), IW'(n_adone),
             IW'((vecs[v].exp_adone_idx >= 0) ? 1 : 0));
         chk($sformatf("v%0d_all_done_cycle", v), IW'(adone_idx), IW'(vecs[v].exp_adone_idx));
         chk($sformatf("v%0d_timeout", v), IW'(timeout), IW'(vecs[v].exp_to));
         if (vecs[v].count > 0)
            chk($sformatf("v%0d_first_work_cycle", v), IW'(first_work), IW'(3));
         repeat (5) @(negedge clk);
      end

      // Reset in the middle of RUN, then a fresh sequence from a new base.
      vcu_delay = 5;
      @(negedge clk);
      start = 1'b1;
      insn_base = 10'd0;
      insn_count = 11'd3;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("pre_rst_busy", IW'(busy), IW'(1));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_insn", insn, '0);
      chk("midrst_work_en", IW'(work_en), '0);
      chk("midrst_r_en", IW'(r_en_insn), '0);
      chk("midrst_r_addr", IW'(r_addr_insn), '0);
      chk("midrst_busy", IW'(busy), '0);
      chk("midrst_all_done", IW'(all_done), '0);
      chk("midrst_timeout", IW'(timeout), '0);
      chk("midrst_issued_cnt", IW'(issued_cnt), '0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      run_seq(300, 2, 4, -1, n_work, n_ren, n_adone, adone_idx, first_work);
      chk("postrst_work_pulses", IW'(n_work), IW'(2));
      chk("postrst_issued_cnt", IW'(issued_cnt), IW'(2));
      chk("postrst_all_done_cycle", IW'(adone_idx), IW'(15));
      chk("postrst_first_work_cycle", IW'(first_work), IW'(3));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
